sobel_gradient: RTL and testbench

- Canny stage 2. Sits directly downstream of the Gaussian smoothing stage and consumes its 8-bit smoothed pixel stream in raster order.
- Builds a 3x3 window from two line buffers and applies the Sobel Gx/Gy kernels.
- Emits, per interior pixel, the gradient magnitude (|Gx|+|Gy|) and a 2-bit quantized direction for the downstream non-maximum-suppression stage.

---
 rtl/canny_pkg.sv | 24 ++
 rtl/sobel_line_buffer.sv | 26 ++
 rtl/sobel_gradient.sv | 187 ++++++++++++++++++
 tb/tb_sobel_gradient.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared definitions for the Canny edge-detection pipeline stages.
package canny_pkg;

  // Default datapath widths: smoothed pixels in, unsaturated |Gx|+|Gy| out
  localparam int PIX_W_DEF = 8;
  localparam int MAG_W_DEF = 11;

  // Quantized gradient direction handed to non-maximum suppression
  typedef enum logic [1:0] {
    DIR_0   = 2'd0,
    DIR_45  = 2'd1,
    DIR_90  = 2'd2,
    DIR_135 = 2'd3
  } dir_t;

  // Sobel kernel weights: outer taps and the centre tap of each column/row
  localparam int SOBEL_W_EDGE = 1;
  localparam int SOBEL_W_MID  = 2;

  // Direction bins split where the minor axis is at most 2/5 of the major axis
  localparam int QUANT_NUM = 5;
  localparam int QUANT_DEN = 2;

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-port line memory, one image row deep. The read is combinational, so
// the old contents at addr are seen in the same cycle that new data is written.
module sobel_line_buffer
  import canny_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int WIDTH = PIX_W_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Write port; contents are deliberately left uninitialised across reset
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/sobel_gradient.sv
// Canny stage 2: 3x3 Sobel gradient magnitude and quantized direction over a
// raster pixel stream. Window shift (E0), Gx/Gy (E1), magnitude/direction (E2).
module sobel_gradient
  import canny_pkg::*;
#(
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int MAG_W      = MAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_sof,
  output logic             out_valid,
  output logic [MAG_W-1:0] out_mag,
  output logic [1:0]       out_dir,
  output logic             out_sof,
  output logic             out_last
);

  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);
  localparam int GRAD_W = PIX_W + 3;
  localparam int ABS_W  = PIX_W + 2;
  localparam int CMP_W  = ABS_W + 3;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  localparam logic signed [GRAD_W-1:0] W_EDGE = GRAD_W'(SOBEL_W_EDGE);
  localparam logic signed [GRAD_W-1:0] W_MID  = GRAD_W'(SOBEL_W_MID);
  localparam logic [CMP_W-1:0]         Q_NUM  = CMP_W'(QUANT_NUM);
  localparam logic [CMP_W-1:0]         Q_DEN  = CMP_W'(QUANT_DEN);

  function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{(GRAD_W - PIX_W){1'b0}}, p});
  endfunction

  logic [COL_W-1:0] col, cur_col, nxt_col;
  logic [ROW_W-1:0] row, cur_row, nxt_row;
  logic             interior, first_ctr, last_ctr;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  logic [PIX_W-1:0] win [3][3];
  logic             v0, sof0, last0;

  logic signed [GRAD_W-1:0] gx_c, gy_c, gx, gy;
  logic                     v1, sof1, last1;

  logic [ABS_W-1:0] ax, ay;
  logic [CMP_W-1:0] ax_num, ay_num, ax_den, ay_den;
  logic [MAG_W-1:0] mag_c;
  dir_t             dir_c;

  // Position of the pixel on the bus (in_sof forces the origin) and its successor
  always_comb begin
    cur_col   = in_sof ? '0 : col;
    cur_row   = in_sof ? '0 : row;
    interior  = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
    first_ctr = (cur_row == ROW_TWO) && (cur_col == COL_TWO);
    last_ctr  = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    nxt_col   = cur_col + COL_W'(1);
    nxt_row   = cur_row;
    if (cur_col == COL_LAST) begin
      nxt_col = '0;
      nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
    end
  end

  // Raster counters advance only on accepted pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      col <= nxt_col;
      row <= nxt_row;
    end
  end

  // lb0 holds the previous row, lb1 the one before; lb1 is fed from lb0's old value
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(COL_W)) u_lb0 (
    .clk     (clk),
    .we      (in_valid),
    .addr    (cur_col),
    .wr_data (in_data),
    .rd_data (lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(COL_W)) u_lb1 (
    .clk     (clk),
    .we      (in_valid),
    .addr    (cur_col),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // E0: shift a new column into the window and tag whether it is centred on an interior pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
      v0    <= 1'b0;
      sof0  <= 1'b0;
      last0 <= 1'b0;
    end else begin
      v0    <= in_valid & interior;
      sof0  <= in_valid & first_ctr;
      last0 <= in_valid & last_ctr;
      if (in_valid) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb1_rd;
        win[1][2] <= lb0_rd;
        win[2][2] <= in_data;
      end
    end
  end

  // Sobel kernels: right column minus left column, bottom row minus top row
  always_comb begin
    gx_c = (W_EDGE * ext(win[0][2]) + W_MID * ext(win[1][2]) + W_EDGE * ext(win[2][2]))
         - (W_EDGE * ext(win[0][0]) + W_MID * ext(win[1][0]) + W_EDGE * ext(win[2][0]));
    gy_c = (W_EDGE * ext(win[2][0]) + W_MID * ext(win[2][1]) + W_EDGE * ext(win[2][2]))
         - (W_EDGE * ext(win[0][0]) + W_MID * ext(win[0][1]) + W_EDGE * ext(win[0][2]));
  end

  // E1: register the signed gradients alongside the validity tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx    <= '0;
      gy    <= '0;
      v1    <= 1'b0;
      sof1  <= 1'b0;
      last1 <= 1'b0;
    end else begin
      gx    <= gx_c;
      gy    <= gy_c;
      v1    <= v0;
      sof1  <= sof0;
      last1 <= last0;
    end
  end

  // Magnitude and direction bin; horizontal wins ties, then vertical, then the diagonals by sign
  always_comb begin
    ax     = gx[GRAD_W-1] ? ABS_W'(-gx) : ABS_W'(gx);
    ay     = gy[GRAD_W-1] ? ABS_W'(-gy) : ABS_W'(gy);
    ax_num = Q_NUM * CMP_W'(ax);
    ay_num = Q_NUM * CMP_W'(ay);
    ax_den = Q_DEN * CMP_W'(ax);
    ay_den = Q_DEN * CMP_W'(ay);
    mag_c  = MAG_W'(ax) + MAG_W'(ay);
    dir_c  = DIR_135;
    if (ay_num <= ax_den)
      dir_c = DIR_0;
    else if (ax_num <= ay_den)
      dir_c = DIR_90;
    else if (gx[GRAD_W-1] == gy[GRAD_W-1])
      dir_c = DIR_45;
  end

  // E2: output registers; frame markers only accompany a valid result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_dir   <= '0;
      out_sof   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= v1;
      out_mag   <= mag_c;
      out_dir   <= dir_c;
      out_sof   <= v1 & sof1;
      out_last  <= v1 & last1;
    end
  end

endmodule

// File: tb/tb_sobel_gradient.sv
// Self-checking bench for sobel_gradient on an 8x8 image, against a frame-level
// model that applies the Sobel kernels directly to the pixels sent so far.
module tb_sobel_gradient;

  localparam int W = 8;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_sof = 1'b0;
  logic        out_valid;
  logic [10:0] out_mag;
  logic [1:0]  out_dir;
  logic        out_sof;
  logic        out_last;

  typedef struct {
    int cyc;
    int mag;
    int dir;
    int sof;
    int last;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   hist [H][W];
  int   br = 0, bc = 0;
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;
  int   n_out = 0, n_special = 0, special_mag = -1;

  sobel_gradient #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8), .MAG_W(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_mag   (out_mag),
    .out_dir   (out_dir),
    .out_sof   (out_sof),
    .out_last  (out_last)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Rising-edge counter used as the time base for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Gradient of the window ending at (r,c), straight from the kernel definitions
  task automatic model(input int r, input int c, output int mag, output int dir);
    int p [3][3];
    int gx, gy, ax, ay;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = hist[r-2+i][c-2+j];
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mag = ax + ay;
    if (5*ay <= 2*ax)               dir = 0;
    else if (5*ax <= 2*ay)          dir = 2;
    else if ((gx < 0) == (gy < 0))  dir = 1;
    else                            dir = 3;
  endtask

  function automatic int pix_of(input int pattern, input int r, input int c);
    case (pattern)
      0: return 100;
      1: return (c >= 4) ? 200 : 0;
      2: return (r >= 4) ? 255 : 0;
      3: return 10 * (r + c);
      4: return 100 + 10 * (c - r);
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // Drive one pixel (after optional idle cycles) and queue the result it enables
  task automatic applyStimulus(input int pix, input bit sof, input int gaps);
    int m, d;
    exp_t e;
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      in_sof   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    if (sof) begin
      br = 0;
      bc = 0;
    end
    hist[br][bc] = pix;
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = 8'(pix);
    if (br >= 2 && bc >= 2) begin
      model(br, bc, m, d);
      e.cyc  = cyc + 3;
      e.mag  = m;
      e.dir  = d;
      e.sof  = (br == 2 && bc == 2) ? 1 : 0;
      e.last = (br == H-1 && bc == W-1) ? 1 : 0;
      expq.push_back(e);
    end
    if (bc == W-1) begin
      bc = 0;
      br = (br == H-1) ? 0 : br + 1;
    end else begin
      bc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int pattern, input int max_gap, input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        applyStimulus(pix_of(pattern, r, c), (r == 0 && c == 0),
                      (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        if (r == stop_r && c == stop_c) return;
      end
  endtask

  task automatic frame_end(input int exp_cnt, input int exp_special);
    repeat (4) @(negedge clk);
    checkOutput("queue drained", expq.size(), 0);
    checkOutput("output count", n_out, exp_cnt);
    if (exp_special >= 0) checkOutput("special mag count", n_special, exp_special);
    n_out = 0;
    n_special = 0;
    expq.delete();
  endtask

  // Output monitor: every result must match the head of the expected queue, on time
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_out++;
      if (int'(out_mag) == special_mag) n_special++;
      if (expq.size() == 0) begin
        checkOutput("unexpected out_valid", 1, 0);
      end else begin
        mon_e = expq.pop_front();
        checkOutput("latency", cyc, mon_e.cyc);
        checkOutput("out_mag", int'(out_mag), mon_e.mag);
        checkOutput("out_dir", int'(out_dir), mon_e.dir);
        checkOutput("out_sof", int'(out_sof), mon_e.sof);
        checkOutput("out_last", int'(out_last), mon_e.last);
      end
    end
  end

  initial begin
    #1;
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_mag", int'(out_mag), 0);
    checkOutput("reset out_dir", int'(out_dir), 0);
    checkOutput("reset out_sof", int'(out_sof), 0);
    checkOutput("reset out_last", int'(out_last), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    special_mag = 0;    send_frame(0, 0, H-1, W-1); frame_end(36, 36);
    special_mag = 800;  send_frame(1, 0, H-1, W-1); frame_end(36, 12);
    special_mag = 1020; send_frame(2, 0, H-1, W-1); frame_end(36, 12);
    special_mag = 160;  send_frame(3, 0, H-1, W-1); frame_end(36, 36);
    special_mag = 160;  send_frame(4, 0, H-1, W-1); frame_end(36, 36);
    special_mag = 800;  send_frame(1, 3, H-1, W-1); frame_end(36, 12);
    special_mag = -1;   send_frame(5, 3, H-1, W-1); frame_end(36, -1);
    special_mag = -1;   send_frame(5, 0, H-1, W-1); frame_end(36, -1);

    // Reset mid-frame after pixel (5,3) is accepted, with results still in flight
    special_mag = 800;
    send_frame(1, 0, 5, 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", int'(out_valid), 0);
    checkOutput("midreset out_mag", int'(out_mag), 0);
    checkOutput("midreset out_dir", int'(out_dir), 0);
    checkOutput("midreset out_sof", int'(out_sof), 0);
    checkOutput("midreset out_last", int'(out_last), 0);
    expq.delete();
    n_out = 0;
    n_special = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("no stray output after reset", n_out, 0);

    // New frame, then in_sof re-asserted at position (4,2) restarts the counters
    send_frame(1, 0, 4, 1);
    frame_end(12, 4);
    send_frame(1, 0, H-1, W-1);
    frame_end(36, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
